comp_sd_decimator: RTL and testbench

- Downstream consumer of the differential SB_IO comparator output (D_IN_1). It closes a first-order sigma-delta loop.
- The synchronised comparator bit drives a feedback pin that charges the external RC node on the comparator's negative input.
- Ones are counted over a fixed power-of-two window, and each count is presented as an unsigned sample on a valid/ready interface for downstream logic.
- Replaces the simple latch-gated LF counter with a deterministic, clocked measurement.

---
 rtl/comp_sd_decimator.sv | 141 ++++++++++++++
 tb/tb_comp_sd_decimator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/comp_sd_decimator.sv
// rtl/comp_sd_decimator.sv - first-order sigma-delta loop closer and ones-count decimator
module comp_sd_decimator #(
    parameter int OSR_LOG2    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int OUT_W       = OSR_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comp_in,
    input  logic             enable,
    output logic             fb_out,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    output logic             busy
);
    localparam int PW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;
    logic [OSR_LOG2-1:0]  wcnt_q, wcnt_d;
    logic [OUT_W-1:0]     acc_q, acc_d;
    logic                 fb_q, fb_d;
    logic [OUT_W-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic                 comp_sync;
    logic [OUT_W-1:0]     comp_ext;
    logic [OUT_W-1:0]     result;
    logic                 win_end;

    // Only the last synchroniser stage may feed the loop.
    assign comp_sync = sync_q[SYNC_STAGES-1];
    assign comp_ext  = {{(OUT_W-1){1'b0}}, comp_sync};
    assign result    = acc_q + comp_ext;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], comp_in};
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        wcnt_d    = wcnt_q;
        acc_d     = acc_q;
        fb_d      = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        win_end   = 1'b0;

        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                wcnt_d = '0;
                acc_d  = '0;
                if (enable) begin
                    state_d   = PRIME;
                    overrun_d = 1'b0;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (pcnt_q == PW'(SYNC_STAGES)) begin
                    state_d = RUN;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                    acc_d   = '0;
                end else begin
                    fb_d   = comp_sync;
                    wcnt_d = wcnt_q + OSR_LOG2'(1);
                    if (wcnt_q == {OSR_LOG2{1'b1}}) begin
                        win_end = 1'b1;
                        acc_d   = '0;
                    end else begin
                        acc_d = result;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Single-entry holding register; a result that finds it full is dropped.
        if (win_end) begin
            if (!valid_q || sample_ready) begin
                data_d  = result;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            pcnt_q    <= '0;
            wcnt_q    <= '0;
            acc_q     <= '0;
            fb_q      <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            pcnt_q    <= pcnt_d;
            wcnt_q    <= wcnt_d;
            acc_q     <= acc_d;
            fb_q      <= fb_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign fb_out       = fb_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_comp_sd_decimator.sv
// tb/tb_comp_sd_decimator.sv - directed self-checking bench for comp_sd_decimator
module tb_comp_sd_decimator;
    localparam int OSR_LOG2 = 4;
    localparam int SYNC     = 2;
    localparam int OUT_W    = OSR_LOG2 + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             comp_in = 1'b0;
    logic             enable = 1'b0;
    logic             fb_out;
    logic [OUT_W-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready = 1'b0;
    logic             overrun;
    logic             busy;

    int total = 0;
    int bad = 0;
    int e;
    logic d1, d2, d3;

    comp_sd_decimator #(.OSR_LOG2(OSR_LOG2), .SYNC_STAGES(SYNC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .comp_in(comp_in), .enable(enable), .fb_out(fb_out),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // e = index of the last rising edge, edge 0 being the one that samples enable=1
    task automatic go_to(input int target);
        while (e < target) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        idle(2);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", sample_valid); end
        total++; if (sample_data !== 5'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", sample_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (fb_out !== 1'b0) begin bad++; $display("FAIL reset_fb got=%0b want=0", fb_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_const_one;
        comp_in = 1'b1; sample_ready = 1'b1; idle(3);
        enable = 1'b1; e = -1;
        go_to(18);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL one_early_valid got=%0b want=0", sample_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL one_busy got=%0b want=1", busy); end
        go_to(19);
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL one_first_valid got=%0b want=1", sample_valid); end
        total++; if (sample_data !== 5'd16) begin bad++; $display("FAIL one_first_data got=%0d want=16", sample_data); end
        go_to(20);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL one_accept got=%0b want=0", sample_valid); end
        go_to(34);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL one_gap_valid got=%0b want=0", sample_valid); end
        go_to(35);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL one_second got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        go_to(51);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL one_third got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        enable = 1'b0;
        go_to(52);
        total++; if (busy !== 1'b0 || fb_out !== 1'b0) begin bad++; $display("FAIL one_stop got busy=%0b fb=%0b want 0 0", busy, fb_out); end
        idle(3);
    endtask

    task automatic test_const_zero;
        comp_in = 1'b0; sample_ready = 1'b1; idle(3);
        enable = 1'b1; e = -1;
        while (e < 51) begin
            @(negedge clk); e++;
            total++; if (fb_out !== 1'b0) begin bad++; $display("FAIL zero_fb edge=%0d got=%0b want=0", e, fb_out); end
            if (e == 18) begin
                total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL zero_early got=%0b want=0", sample_valid); end
            end
            if (e == 19 || e == 35 || e == 51) begin
                total++; if (sample_valid !== 1'b1 || sample_data !== 5'd0) begin bad++; $display("FAIL zero_sample edge=%0d got valid=%0b data=%0d want valid=1 data=0", e, sample_valid, sample_data); end
            end
        end
        enable = 1'b0;
        idle(4);
    endtask

    task automatic test_toggle;
        comp_in = 1'b0; sample_ready = 1'b1; idle(4);
        d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        enable = 1'b1; e = -1;
        while (e < 51) begin
            @(negedge clk); e++;
            if (e >= 4) begin
                total++; if (fb_out !== d3) begin bad++; $display("FAIL toggle_fb edge=%0d got=%0b want=%0b", e, fb_out, d3); end
            end
            if (e == 19 || e == 35 || e == 51) begin
                total++; if (sample_valid !== 1'b1 || sample_data !== 5'd8) begin bad++; $display("FAIL toggle_sample edge=%0d got valid=%0b data=%0d want valid=1 data=8", e, sample_valid, sample_data); end
            end
            d3 = d2; d2 = d1; d1 = ~comp_in;
            comp_in = d1;
        end
        enable = 1'b0; comp_in = 1'b0;
        idle(4);
    endtask

    task automatic test_overrun;
        comp_in = 1'b1; sample_ready = 1'b0; idle(3);
        enable = 1'b1; e = -1;
        go_to(19);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL ovr_first got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%0b want=0", overrun); end
        comp_in = 1'b0;
        go_to(34);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16 || overrun !== 1'b0) begin bad++; $display("FAIL ovr_hold got valid=%0b data=%0d ovr=%0b want 1 16 0", sample_valid, sample_data, overrun); end
        go_to(35);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL ovr_keep got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b want=1", overrun); end
        sample_ready = 1'b1;
        go_to(36);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%0b want=0", sample_valid); end
        go_to(50);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL ovr_gap got=%0b want=0", sample_valid); end
        go_to(51);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd0) begin bad++; $display("FAIL ovr_next got valid=%0b data=%0d want valid=1 data=0", sample_valid, sample_data); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b want=1", overrun); end
        enable = 1'b0;
        idle(4);
    endtask

    task automatic test_disable_mid_window;
        comp_in = 1'b1; sample_ready = 1'b1; idle(3);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL dis_prev_overrun got=%0b want=1", overrun); end
        enable = 1'b1; e = -1;
        go_to(0);
        total++; if (overrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL dis_start got ovr=%0b busy=%0b want 0 1", overrun, busy); end
        go_to(10);
        total++; if (fb_out !== 1'b1) begin bad++; $display("FAIL dis_fb_run got=%0b want=1", fb_out); end
        enable = 1'b0;
        go_to(11);
        total++; if (busy !== 1'b0 || fb_out !== 1'b0 || sample_valid !== 1'b0) begin bad++; $display("FAIL dis_stop got busy=%0b fb=%0b valid=%0b want 0 0 0", busy, fb_out, sample_valid); end
        go_to(30);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL dis_no_sample got=%0b want=0", sample_valid); end
        enable = 1'b1; e = -1;
        go_to(18);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL dis_re_early got=%0b want=0", sample_valid); end
        go_to(19);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL dis_re_sample got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        enable = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_mid_window;
        comp_in = 1'b1; sample_ready = 1'b0; idle(3);
        enable = 1'b1; e = -1;
        go_to(25);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL rst_pending got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        rst = 1'b1;
        #1;
        total++; if (sample_valid !== 1'b0 || sample_data !== 5'd0) begin bad++; $display("FAIL rst_async_out got valid=%0b data=%0d want 0 0", sample_valid, sample_data); end
        total++; if (busy !== 1'b0 || fb_out !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rst_async_ctl got busy=%0b fb=%0b ovr=%0b want 0 0 0", busy, fb_out, overrun); end
        @(negedge clk);
        rst = 1'b0; e = -1;
        go_to(0);
        total++; if (busy !== 1'b1 || sample_valid !== 1'b0) begin bad++; $display("FAIL rst_restart got busy=%0b valid=%0b want 1 0", busy, sample_valid); end
        go_to(18);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_no_partial got=%0b want=0", sample_valid); end
        go_to(19);
        total++; if (sample_valid !== 1'b1 || sample_data !== 5'd16) begin bad++; $display("FAIL rst_full_window got valid=%0b data=%0d want valid=1 data=16", sample_valid, sample_data); end
        enable = 1'b0; sample_ready = 1'b1;
        idle(3);
    endtask

    initial begin
        test_reset;
        test_const_one;
        test_const_zero;
        test_toggle;
        test_overrun;
        test_disable_mid_window;
        test_reset_mid_window;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
